// File: rtl/st_output_port.sv
// Router output port: per-cycle switch-traversal arbitration with packet locking
// (wormhole ownership), round-robin fairness between packets and downstream credit tracking.
module st_output_port #(
  parameter int unsigned CREDIT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] st_req,
  input  logic [4:0] st_tail,
  input  logic       credit_in,
  output logic       out_en,
  output logic [4:0] grant,
  output logic [2:0] xbar_sel,
  output logic       locked,
  output logic [3:0] credit_cnt,
  output logic       credit_err
);

  localparam logic [3:0] MaxCredit = 4'(CREDIT_DEPTH);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] credit_q, credit_d;
  logic       err_q, err_d;
  logic       out_en_q, out_en_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;

  logic [9:0] req_rot;
  logic [2:0] rr_off;
  logic [3:0] rr_sum;
  logic [2:0] rr_winner;

  // Rotate the request vector so bit 0 is rr_ptr, pick the lowest set bit, map back mod 5.
  always_comb begin
    req_rot = {st_req, st_req} >> rr_ptr_q;
    rr_off  = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (req_rot[i]) rr_off = 3'(i);
    end
    rr_sum    = {1'b0, rr_ptr_q} + {1'b0, rr_off};
    rr_winner = (rr_sum >= 4'd5) ? 3'(rr_sum - 4'd5) : rr_sum[2:0];
  end

  logic [2:0] cand;
  logic [4:0] cand_oh;
  logic       xfer;
  logic       cand_tail;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    credit_d = credit_q;
    err_d    = err_q;

    // While locked only the owner may traverse; no credit means no decision at all.
    cand      = (state_q == StLocked) ? owner_q : rr_winner;
    cand_oh   = 5'b00001 << cand;
    xfer      = (credit_q != 4'd0) && ((st_req & cand_oh) != 5'd0);
    cand_tail = (st_tail & cand_oh) != 5'd0;

    out_en_d = xfer;
    grant_d  = xfer ? cand_oh : 5'd0;
    sel_d    = xfer ? cand : 3'd0;

    if (xfer) begin
      if (cand_tail) begin
        state_d  = StIdle;
        rr_ptr_d = (cand == 3'd4) ? 3'd0 : cand + 3'd1;
      end else begin
        state_d = StLocked;
        owner_d = cand;
      end
    end

    if (xfer && !credit_in) begin
      credit_d = credit_q - 4'd1;
    end else if (!xfer && credit_in) begin
      if (credit_q == MaxCredit) err_d = 1'b1;
      else                       credit_d = credit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      credit_q <= MaxCredit;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
      grant_q  <= 5'd0;
      sel_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      out_en_q <= out_en_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
    end
  end

  assign out_en     = out_en_q;
  assign grant      = grant_q;
  assign xbar_sel   = sel_q;
  assign locked     = (state_q == StLocked);
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

endmodule
